clz_issue_ctrl: RTL and testbench

- Sequencer between the register-file read stage and the CLZ unit of the multicycle CPU.
- Latches the rs operand and the rd index on a start pulse, and drives the operand onto the CLZ input.
- Issues the CLZ strobe, waits for the result, captures it, and performs the register-file writeback through a req/ack handshake.
- Exposes busy/done to the main control FSM; supports flush on exception.

---
 rtl/clz_issue_if.sv | 41 ++++
 rtl/clz_issue_ctrl.sv | 106 ++++++++++
 tb/tb_clz_issue_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/clz_issue_if.sv
// Issue/writeback bundle between the control FSM, the CLZ unit and the register file.
// The clo_sel line exists only when CLZ_CLO_EN is defined.
interface clz_issue_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              start;
  logic [DATA_W-1:0] op_a;
  logic [ADDR_W-1:0] rd_idx;
  logic              abort;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] clz_data;
  logic              clz_strobe;
  logic [DATA_W-1:0] clz_result;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              wb_ack;
`ifdef CLZ_CLO_EN
  logic              clo_sel;

  modport master (
    output start, op_a, rd_idx, abort, clz_result, wb_ack, clo_sel,
    input  busy, done, clz_data, clz_strobe, wb_en, wb_addr, wb_data
  );
  modport slave (
    input  start, op_a, rd_idx, abort, clz_result, wb_ack, clo_sel,
    output busy, done, clz_data, clz_strobe, wb_en, wb_addr, wb_data
  );
`else
  modport master (
    output start, op_a, rd_idx, abort, clz_result, wb_ack,
    input  busy, done, clz_data, clz_strobe, wb_en, wb_addr, wb_data
  );
  modport slave (
    input  start, op_a, rd_idx, abort, clz_result, wb_ack,
    output busy, done, clz_data, clz_strobe, wb_en, wb_addr, wb_data
  );
`endif
endinterface

// File: rtl/clz_issue_ctrl.sv
// Sequences one CLZ operation: latch operand, setup, strobe, wait, capture, writeback.
// Optional CLZ_CLO_EN: clo_sel inverts the stored operand to count leading ones.
module clz_issue_ctrl #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int WAIT_CYC = 1
) (
  input  logic clk,
  input  logic rst_n,
  clz_issue_if.slave bus
);

  typedef enum logic [2:0] {IDLE, DRIVE, STROBE, WAIT, WB} state_t;

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYC);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] opnd_q, opnd_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              strobe_q, strobe_d;
  logic              wb_en_q, wb_en_d;
  logic              done_q, done_d;

  logic              flush, accept, last_wait;
  logic [DATA_W-1:0] op_in;

  // Abort only matters once an operation is in flight; it also vetoes a same-cycle start.
  assign flush     = bus.abort && (state_q != IDLE);
  assign accept    = (state_q == IDLE) && bus.start && !bus.abort;
  assign last_wait = (state_q == WAIT) && (cnt_q <= 4'd1);

`ifdef CLZ_CLO_EN
  assign op_in = bus.clo_sel ? ~bus.op_a : bus.op_a;
`else
  assign op_in = bus.op_a;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      opnd_q   <= '0;
      data_q   <= '0;
      addr_q   <= '0;
      cnt_q    <= '0;
      strobe_q <= 1'b0;
      wb_en_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      opnd_q   <= opnd_d;
      data_q   <= data_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      strobe_q <= strobe_d;
      wb_en_q  <= wb_en_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = DRIVE;
      DRIVE:   state_d = STROBE;
      STROBE:  state_d = WAIT;
      WAIT:    if (last_wait) state_d = (addr_q != '0) ? WB : IDLE;
      WB:      if (bus.wb_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_comb begin
    opnd_d = opnd_q;
    addr_d = addr_q;
    data_d = data_q;
    cnt_d  = cnt_q;
    if (accept) begin
      opnd_d = op_in;
      addr_d = bus.rd_idx;
    end
    if (flush)
      cnt_d = '0;
    else if (state_q == STROBE)
      cnt_d = WAIT_LD;
    else if (state_q == WAIT)
      cnt_d = cnt_q - 4'd1;
    if (last_wait && !flush) data_d = bus.clz_result;
    // Strobe and wb_en are registered from the upcoming state so they align with it.
    strobe_d = (state_d == STROBE);
    wb_en_d  = (state_d == WB);
    done_d   = !flush && ((last_wait && addr_q == '0) ||
                          (state_q == WB && bus.wb_ack));
  end

  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = done_q;
  assign bus.clz_data   = opnd_q;
  assign bus.clz_strobe = strobe_q && !flush;
  assign bus.wb_en      = wb_en_q && !flush;
  assign bus.wb_addr    = addr_q;
  assign bus.wb_data    = data_q;

endmodule

// File: tb/tb_clz_issue_ctrl.sv
// Directed bench for clz_issue_ctrl with WAIT_CYC=1 and a behavioural CLZ unit.
module tb_clz_issue_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  clz_issue_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  clz_issue_ctrl #(.DATA_W(32), .ADDR_W(5), .WAIT_CYC(1)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] clz32(input logic [31:0] v);
    logic [31:0] n;
    n = 32'd32;
    for (int i = 0; i < 32; i++) if (v[i]) n = 32'(31 - i);
    return n;
  endfunction

  assign bus.clz_result = clz32(bus.clz_data);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.start = 0; bus.op_a = '0; bus.rd_idx = '0; bus.abort = 0; bus.wb_ack = 0;
`ifdef CLZ_CLO_EN
    bus.clo_sel = 0;
`endif
    #2;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_strobe", bus.clz_strobe, 0);
    chk("rst_wb_en", bus.wb_en, 0);
    chk("rst_clz_data", bus.clz_data, 0);
    chk("rst_wb_addr", bus.wb_addr, 0);
    chk("rst_wb_data", bus.wb_data, 0);
    #10 rst_n = 1;
    step();

    // T1: basic latency, ack tied high
    bus.op_a = 32'h0001_0000; bus.rd_idx = 8; bus.start = 1; bus.wb_ack = 1;
    step(); bus.start = 0;
    chk("t1_c1_busy", bus.busy, 1);
    chk("t1_c1_strobe", bus.clz_strobe, 0);
    chk("t1_c1_clz_data", bus.clz_data, 32'h0001_0000);
    step(); chk("t1_c2_strobe", bus.clz_strobe, 1);
    step(); chk("t1_c3_strobe", bus.clz_strobe, 0); chk("t1_c3_wb_en", bus.wb_en, 0);
    step();
    chk("t1_c4_wb_en", bus.wb_en, 1);
    chk("t1_c4_wb_addr", bus.wb_addr, 8);
    chk("t1_c4_wb_data", bus.wb_data, 15);
    chk("t1_c4_done", bus.done, 0);
    step();
    chk("t1_c5_done", bus.done, 1);
    chk("t1_c5_busy", bus.busy, 0);
    chk("t1_c5_wb_en", bus.wb_en, 0);
    step(); chk("t1_c6_done", bus.done, 0);

    // T2: writeback stall of 5 cycles
    bus.op_a = 32'h0; bus.rd_idx = 3; bus.start = 1; bus.wb_ack = 0;
    step(); bus.start = 0;
    step(); step(); step();
    for (int i = 0; i < 5; i++) begin
      chk("t2_stall_wb_en", bus.wb_en, 1);
      chk("t2_stall_wb_addr", bus.wb_addr, 3);
      chk("t2_stall_wb_data", bus.wb_data, 32);
      chk("t2_stall_done", bus.done, 0);
      step();
    end
    bus.wb_ack = 1;
    chk("t2_ack_wb_en", bus.wb_en, 1);
    step(); bus.wb_ack = 0;
    chk("t2_done", bus.done, 1);
    chk("t2_wb_en_drop", bus.wb_en, 0);
    step();
    chk("t2_done_once", bus.done, 0);
    chk("t2_busy", bus.busy, 0);

    // T3: rd=0 discards the result
    bus.op_a = 32'h1; bus.rd_idx = 0; bus.start = 1; bus.wb_ack = 1;
    step(); bus.start = 0;
    step(); chk("t3_strobe", bus.clz_strobe, 1);
    step(); chk("t3_c3_wb_en", bus.wb_en, 0);
    step();
    chk("t3_c4_wb_en", bus.wb_en, 0);
    chk("t3_done", bus.done, 1);
    chk("t3_busy", bus.busy, 0);
    chk("t3_wb_data", bus.wb_data, 31);
    step();
    chk("t3_done_once", bus.done, 0);
    chk("t3_c5_wb_en", bus.wb_en, 0);

    // T4: abort during STROBE, then a clean restart
    bus.op_a = 32'h0000_0F00; bus.rd_idx = 5; bus.start = 1;
    step(); bus.start = 0;
    step(); bus.abort = 1; #1;
    chk("t4_strobe_masked", bus.clz_strobe, 0);
    chk("t4_busy_abort", bus.busy, 1);
    step(); bus.abort = 0;
    chk("t4_idle", bus.busy, 0);
    chk("t4_no_wb_en", bus.wb_en, 0);
    chk("t4_no_done", bus.done, 0);
    step();
    chk("t4_no_wb_en2", bus.wb_en, 0);
    chk("t4_no_done2", bus.done, 0);
    bus.start = 1;
    step(); bus.start = 0;
    step(); chk("t4_re_strobe", bus.clz_strobe, 1);
    step(); step();
    chk("t4_re_wb_en", bus.wb_en, 1);
    chk("t4_re_wb_addr", bus.wb_addr, 5);
    chk("t4_re_wb_data", bus.wb_data, 20);
    step(); chk("t4_re_done", bus.done, 1);

    // T5: start while busy and start with wb_ack are both ignored
    bus.op_a = 32'h00FF_0000; bus.rd_idx = 7; bus.start = 1;
    step();
    bus.op_a = 32'hFFFF_FFFF; bus.rd_idx = 9;
    chk("t5_busy", bus.busy, 1);
    step(); bus.start = 0;
    chk("t5_clz_data", bus.clz_data, 32'h00FF_0000);
    step(); step();
    chk("t5_wb_en", bus.wb_en, 1);
    chk("t5_wb_addr", bus.wb_addr, 7);
    chk("t5_wb_data", bus.wb_data, 8);
    bus.start = 1;
    step(); bus.start = 0;
    chk("t5_done", bus.done, 1);
    chk("t5_busy_ack_start", bus.busy, 0);
    step();
    chk("t5_no_queue", bus.busy, 0);
    chk("t5_addr_kept", bus.wb_addr, 7);

    // T6: abort in IDLE is inert; abort beats a same-cycle start
    bus.abort = 1;
    step();
    chk("t6_idle_abort_busy", bus.busy, 0);
    chk("t6_idle_abort_done", bus.done, 0);
    bus.start = 1; bus.op_a = 32'h1; bus.rd_idx = 2;
    step(); bus.start = 0; bus.abort = 0;
    chk("t6_start_dropped", bus.busy, 0);
    chk("t6_addr_unlatched", bus.wb_addr, 7);

    // T7: reset while stalled in writeback
    bus.op_a = 32'h0; bus.rd_idx = 6; bus.start = 1; bus.wb_ack = 0;
    step(); bus.start = 0;
    step(); step(); step();
    chk("t7_wb_en", bus.wb_en, 1);
    rst_n = 0; #1;
    chk("t7_rst_wb_en", bus.wb_en, 0);
    chk("t7_rst_busy", bus.busy, 0);
    chk("t7_rst_wb_addr", bus.wb_addr, 0);
    chk("t7_rst_wb_data", bus.wb_data, 0);
    rst_n = 1;
    step();
    chk("t7_post_busy", bus.busy, 0);

`ifdef CLZ_CLO_EN
    // T8: count leading ones
    bus.clo_sel = 1; bus.op_a = 32'hFFFF_0000; bus.rd_idx = 4; bus.start = 1; bus.wb_ack = 1;
    step(); bus.start = 0; bus.clo_sel = 0;
    chk("t8_clz_data", bus.clz_data, 32'h0000_FFFF);
    step(); chk("t8_strobe", bus.clz_strobe, 1);
    step(); step();
    chk("t8_wb_en", bus.wb_en, 1);
    chk("t8_wb_addr", bus.wb_addr, 4);
    chk("t8_wb_data", bus.wb_data, 16);
    step(); chk("t8_done", bus.done, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
